// File: rtl/uart_tx_feeder_pkg.sv
// Shared definitions for the UART transmit feeder: feeder FSM encoding and
// the width helper used to size pointers and counters.
package uart_tx_feeder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD      = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } feeder_state_e;

    // Smallest n with 2**n >= value; returns 0 for value <= 1.
    function automatic int ceil_log2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_tx_feeder_sync_fifo.sv
// Single-clock FIFO with unregistered read port so storage maps onto
// distributed RAM. Callers must not push when full or pop when empty.
module sync_fifo
    import uart_tx_feeder_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int DEPTH     = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [DATA_BITS-1:0]       din_i,
    output logic [DATA_BITS-1:0]       dout_o,
    output logic [ceil_log2(DEPTH):0]  count_o
);

    localparam int AW = ceil_log2(DEPTH);

    logic [DATA_BITS-1:0] mem_q [DEPTH];
    logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [AW-1:0]        wr_ptr_d, rd_ptr_d;
    logic [AW:0]          count_q, count_d;

    // Storage is deliberately left out of reset so it can infer as RAM.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push_i && !pop_i) begin
            count_d = count_q + (AW+1)'(1);
        end else if (pop_i && !push_i) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers upstream words and hands them one at a time to a uart_tx,
// pulsing tx_start once per word and waiting out the busy window.
module uart_tx_feeder
    import uart_tx_feeder_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [DATA_BITS-1:0]            in_word,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic [DATA_BITS-1:0]            tx_word,
    output logic                            tx_start,
    input  logic                            tx_busy,
    output logic [ceil_log2(FIFO_DEPTH):0]  fifo_count,
    output logic                            overflow,
    output logic [1:0]                      dbg_state_o
);

    localparam int CW = ceil_log2(FIFO_DEPTH) + 1;

    feeder_state_e        state_q, state_d;
    logic [DATA_BITS-1:0] tx_word_q, tx_word_d;
    logic                 overflow_q, overflow_d;
    logic                 push, pop;
    logic [DATA_BITS-1:0] fifo_dout;
    logic [CW-1:0]        count;

    // Upstream handshake: a word transfers on any rising edge where in_valid
    // and in_ready are both high. in_ready depends only on registered count,
    // and in_valid while full drops the word and latches overflow.
    assign in_ready = (count != CW'(FIFO_DEPTH));
    assign push     = in_valid & in_ready;

    sync_fifo #(
        .DATA_BITS (DATA_BITS),
        .DEPTH     (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (in_word),
        .dout_o  (fifo_dout),
        .count_o (count)
    );

    always_comb begin
        state_d    = state_q;
        pop        = 1'b0;
        tx_start   = 1'b0;
        overflow_d = overflow_q | (in_valid & ~in_ready);
        case (state_q)
            ST_IDLE: begin
                if (count != '0 && !tx_busy) begin
                    pop     = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                tx_start = 1'b1;
                state_d  = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        tx_word_d = pop ? fifo_dout : tx_word_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            tx_word_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_word_q  <= tx_word_d;
            overflow_q <= overflow_d;
        end
    end

    assign tx_word     = tx_word_q;
    assign fifo_count  = count;
    assign overflow    = overflow_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder with a small uart_tx busy model and an
// in-order scoreboard of words expected on tx_word at each tx_start.
module tb_uart_tx_feeder;
    import uart_tx_feeder_pkg::*;

    localparam int BUSY_LEN = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_word = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] tx_word;
    logic       tx_start;
    logic       tx_busy;
    logic [4:0] fifo_count;
    logic       overflow;
    logic [1:0] dbg_state;

    logic       model_busy = 1'b0;
    logic       hold_busy = 1'b0;
    logic       seen_start = 1'b0;
    int         busy_cnt = 0;

    int         n_vec = 0;
    int         n_err = 0;
    int         n_starts = 0;
    int         n_exp_starts = 0;
    logic [7:0] exp_q[$];

    assign tx_busy = model_busy | hold_busy;

    uart_tx_feeder #(
        .DATA_BITS  (8),
        .FIFO_DEPTH (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_word     (in_word),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .tx_word     (tx_word),
        .tx_start    (tx_start),
        .tx_busy     (tx_busy),
        .fifo_count  (fifo_count),
        .overflow    (overflow),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every tx_start must present the oldest outstanding word.
    initial begin
        forever begin
            @(negedge clk);
            seen_start = tx_start;
            if (tx_start === 1'b1) begin
                n_starts++;
                if (exp_q.size() == 0) begin
                    check_eq("tx_spurious", 32'(tx_start), 32'd0);
                end else begin
                    check_eq("tx_order", 32'(tx_word), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    // uart_tx model: registered busy rising the cycle after tx_start.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (busy_cnt > 0) busy_cnt--;
            if (seen_start) busy_cnt = BUSY_LEN;
            model_busy = (busy_cnt > 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_word(input logic [7:0] w, input bit wait_rdy);
        int c;
        c = 0;
        while (wait_rdy && !in_ready && c < 200) begin
            tick(1);
            c++;
        end
        if (wait_rdy) check_eq("push_ready_timeout", 32'(c >= 200), 32'd0);
        in_word  = w;
        in_valid = 1'b1;
        if (in_ready) begin
            exp_q.push_back(w);
            n_exp_starts++;
        end
        tick(1);
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tag, input int max_cyc);
        int c;
        c = 0;
        while (c < max_cyc && !(exp_q.size() == 0 && dbg_state == ST_IDLE &&
                                fifo_count == 5'd0 && tx_busy == 1'b0)) begin
            @(negedge clk);
            c++;
        end
        check_eq(tag, 32'(c >= max_cyc), 32'd0);
        tick(1);
    endtask

    initial begin
        int c;
        int s;

        // Reset values
        tick(2);
        check_eq("rst_count", 32'(fifo_count), 32'd0);
        check_eq("rst_start", 32'(tx_start), 32'd0);
        check_eq("rst_word", 32'(tx_word), 32'd0);
        check_eq("rst_ovf", 32'(overflow), 32'd0);
        check_eq("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        rst = 1'b0;
        tick(1);
        check_eq("rst_ready", 32'(in_ready), 32'd1);

        // Single word: count 1 then 0, start two cycles after the push cycle
        push_word(8'hA5, 1'b0);
        @(negedge clk);
        check_eq("single_cnt1", 32'(fifo_count), 32'd1);
        check_eq("single_nostart", 32'(tx_start), 32'd0);
        @(negedge clk);
        check_eq("single_start", 32'(tx_start), 32'd1);
        check_eq("single_word", 32'(tx_word), 32'hA5);
        check_eq("single_cnt0", 32'(fifo_count), 32'd0);
        @(negedge clk);
        check_eq("single_pulse_end", 32'(tx_start), 32'd0);
        check_eq("single_word_hold", 32'(tx_word), 32'hA5);
        tick(1);
        drain("single_drain", 100);
        check_eq("single_nstarts", 32'(n_starts), 32'd1);

        // Burst of 16 on consecutive cycles
        for (int i = 1; i <= 16; i++) begin
            check_eq("burst_ready", 32'(in_ready), 32'd1);
            push_word(8'(i), 1'b0);
        end
        drain("burst_drain", 600);

        // Overflow: downstream stuck busy, 17 offers
        hold_busy = 1'b1;
        for (int i = 0; i < 17; i++) begin
            push_word(8'hB0 + 8'(i), 1'b0);
        end
        check_eq("ovf_count", 32'(fifo_count), 32'd16);
        check_eq("ovf_ready", 32'(in_ready), 32'd0);
        check_eq("ovf_flag", 32'(overflow), 32'd1);
        tick(3);
        check_eq("ovf_sticky", 32'(overflow), 32'd1);
        hold_busy = 1'b0;
        drain("ovf_drain", 600);
        check_eq("ovf_sticky_drained", 32'(overflow), 32'd1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(1);
        check_eq("ovf_cleared", 32'(overflow), 32'd0);

        // Wrap-around: 40 words with gaps, pointers wrap twice
        for (int i = 0; i < 40; i++) begin
            tick($urandom_range(0, 3));
            push_word(8'h40 + 8'(i), 1'b1);
        end
        drain("wrap_drain", 1500);
        check_eq("wrap_no_ovf", 32'(overflow), 32'd0);
        check_eq("wrap_nstarts", 32'(n_starts), 32'(n_exp_starts));

        // Push on the IDLE-to-LOAD cycle with three words stored
        hold_busy = 1'b1;
        push_word(8'hC1, 1'b0);
        push_word(8'hC2, 1'b0);
        push_word(8'hC3, 1'b0);
        check_eq("simul_pre", 32'(fifo_count), 32'd3);
        hold_busy = 1'b0;
        push_word(8'hC4, 1'b0);
        @(negedge clk);
        check_eq("simul_count", 32'(fifo_count), 32'd3);
        check_eq("simul_state", 32'(dbg_state), 32'(ST_LOAD));
        tick(1);
        drain("simul_drain", 300);

        // Reset during WAIT_DONE with five words buffered
        hold_busy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            push_word(8'hD0 + 8'(i), 1'b0);
        end
        hold_busy = 1'b0;
        c = 0;
        while (c < 100 && dbg_state != ST_WAIT_DONE) begin
            @(negedge clk);
            c++;
        end
        check_eq("rmid_reach_wait_done", 32'(c >= 100), 32'd0);
        check_eq("rmid_pre_count", 32'(fifo_count), 32'd5);
        rst = 1'b1;
        #1;
        check_eq("rmid_count", 32'(fifo_count), 32'd0);
        check_eq("rmid_start", 32'(tx_start), 32'd0);
        check_eq("rmid_state", 32'(dbg_state), 32'(ST_IDLE));
        n_exp_starts -= exp_q.size();
        exp_q.delete();
        tick(2);
        rst = 1'b0;
        s = n_starts;
        tick(30);
        check_eq("rmid_quiet", 32'(n_starts), 32'(s));
        check_eq("rmid_idle", 32'(dbg_state), 32'(ST_IDLE));
        push_word(8'h77, 1'b0);
        drain("rmid_resume", 100);
        check_eq("rmid_resumed", 32'(n_starts), 32'(s + 1));

        check_eq("total_starts", 32'(n_starts), 32'(n_exp_starts));
        check_eq("final_empty", 32'(fifo_count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_feeder.md
UART_TX_FEEDER -- requirements
Module: uart_tx_feeder

Interface
REQ-001 Parameter DATA_BITS, default 8, width of each data word; SHALL match the downstream uart_tx DATA_BITS.
REQ-002 Parameter FIFO_DEPTH, default 16, buffer capacity in words; SHALL be a power of two, at least 2.
REQ-003 clk  input  1  single system clock; all logic SHALL be on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_word  input  DATA_BITS  upstream data word.
REQ-006 in_valid  input  1  upstream asserts when in_word is valid.
REQ-007 in_ready  output  1  high when a word can be accepted; a push occurs on a cycle where in_valid and in_ready are both high.
REQ-008 tx_word  output  DATA_BITS  word presented to the uart_tx word input.
REQ-009 tx_start  output  1  single-cycle start pulse to the uart_tx tx_start input.
REQ-010 tx_busy  input  1  uart_tx busy flag; registered, so it rises one cycle after tx_start.
REQ-011 fifo_count  output  ceil_log2(FIFO_DEPTH)+1  number of stored words, from 0 to FIFO_DEPTH.
REQ-012 overflow  output  1  sticky flag, set when in_valid is high while the FIFO is full.

Function
REQ-013 in_ready SHALL equal (fifo_count != FIFO_DEPTH), decoded from registered state with no combinational path from in_valid.
REQ-014 A push SHALL write in_word at the write pointer, then increment the pointer modulo FIFO_DEPTH.
REQ-015 A pop SHALL increment the read pointer modulo FIFO_DEPTH.
REQ-016 fifo_count SHALL change by +1 on push only, -1 on pop only, and 0 on simultaneous push and pop.
REQ-017 When full, a push and a pop in the same cycle SHALL be impossible, because in_ready is low; a word offered while full SHALL be dropped and overflow set.
REQ-018 The FSM SHALL have four states: IDLE, LOAD, WAIT_BUSY, WAIT_DONE.
REQ-019 IDLE: if fifo_count != 0 and tx_busy == 0, the FSM SHALL pop the head word into tx_word and go to LOAD; otherwise it stays in IDLE.
REQ-020 LOAD: tx_start SHALL be high for exactly this one cycle, with tx_word stable; the next state is WAIT_BUSY.
REQ-021 WAIT_BUSY: the FSM SHALL stay until tx_busy == 1, then go to WAIT_DONE.
REQ-022 WAIT_DONE: the FSM SHALL stay while tx_busy == 1, then go to IDLE.
REQ-023 tx_word SHALL hold its value from LOAD until the next pop.
REQ-024 tx_start SHALL never be high outside LOAD; at most one pulse per popped word.
REQ-025 Latency, non-empty FIFO with uart_tx idle: tx_start SHALL rise 2 cycles after the push edge (push, then IDLE pop, then LOAD).
REQ-026 Back-to-back words SHALL be separated by at least WAIT_BUSY + WAIT_DONE + IDLE + LOAD; no word is lost or duplicated.
REQ-027 fifo_count SHALL decrement in the IDLE-to-LOAD cycle; a push in that same cycle is permitted and nets zero change.
REQ-028 The FIFO SHALL wrap pointers seamlessly; order is preserved across wrap-around.

Reset
REQ-029 On rst high, asynchronously: state = IDLE, pointers = 0, fifo_count = 0, tx_start = 0, tx_word = 0, overflow = 0.
REQ-030 in_ready SHALL read 1 once rst is released.
REQ-031 Reset mid-transmission SHALL discard all buffered words; the FSM returns to IDLE regardless of tx_busy, then resumes per REQ-019.
REQ-032 FIFO storage contents need not be reset.

Structure
REQ-033 ceil_log2 and the FSM state encoding constants SHALL come from the shared verilog_utils header.
REQ-034 Buffering SHALL be a separate sub-module sync_fifo, with parameters DATA_BITS and DEPTH and ports push, pop, din, dout, count; the FSM lives in uart_tx_feeder.
REQ-035 The top level SHALL be synthesizable with inferred distributed RAM for storage.

Verification
REQ-036 Single word: push 0xA5 with uart_tx idle -> tx_start pulses once, 2 cycles later, with tx_word = 0xA5; fifo_count goes 1 then 0.
REQ-037 Burst: push 0x01..0x10 on consecutive cycles (DEPTH=16) with a uart_tx model at 9600 baud and 100 MHz -> line carries 0x01..0x10 in order; in_ready stays high.
REQ-038 Overflow: hold tx_busy = 1, push 17 words -> fifo_count = 16, in_ready = 0, 17th word dropped, overflow = 1 and sticky.
REQ-039 Wrap-around: 40 words pushed in random gaps -> all 40 emitted in order, with pointer wrap exercised twice.
REQ-040 Simultaneous push and pop: push exactly on the IDLE-to-LOAD cycle with fifo_count = 3 -> fifo_count stays 3.
REQ-041 Reset mid-operation: assert rst during WAIT_DONE with 5 words buffered -> fifo_count = 0, tx_start = 0, state IDLE; no further tx_start until a new push.
